// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle controller and the datapath/memory side.
// The controller owns the master modport; the datapath (or bench) uses slave.
interface multicycle_control_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       irwrite;
  logic       pcwrite;
  logic       pcwritecond;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [2:0] alucontrol;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic [3:0] state;
  logic       illegal_instr;
  logic       bus_error;
  logic       retired;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_req, mem_we, iord, irwrite, pcwrite, pcwritecond, pcsrc,
           alusrca, alusrcb, alucontrol, regdst, memtoreg, regwrite,
           state, illegal_instr, bus_error, retired
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_req, mem_we, iord, irwrite, pcwrite, pcwritecond, pcsrc,
           alusrca, alusrcb, alucontrol, regdst, memtoreg, regwrite,
           state, illegal_instr, bus_error, retired
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS-subset controller: sequences fetch/decode/execute/memory/write-back
// over one shared memory port with a req/ready handshake and a wait timeout.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT  = 255,
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11,
    ILLEGAL = 4'd12,
    HALT    = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_SLT = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  localparam int            CW   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  state_t        state_q;
  state_t        next_state;
  logic [CW-1:0] wait_cnt;
  logic          mem_state;
  logic          timeout;
  logic          rtype_legal;

  // zero reaches the PC through pcwritecond in the datapath; the controller never reads it.
  logic unused_zero;
  assign unused_zero = bus.zero;

  assign mem_state   = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
  assign timeout     = (MEM_TIMEOUT != 0) && mem_state && !bus.mem_ready && (wait_cnt == LAST);
  assign rtype_legal = (bus.funct == FN_ADD) || (bus.funct == FN_SUB) || (bus.funct == FN_AND) ||
                       (bus.funct == FN_OR)  || (bus.funct == FN_SLT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      wait_cnt <= '0;
    end else begin
      state_q <= next_state;
      if ((next_state != state_q) || timeout)
        wait_cnt <= '0;
      else if (mem_state && !bus.mem_ready)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // A timed-out memory state abandons the instruction and refetches.
  always_comb begin
    next_state = state_q;
    case (state_q)
      FETCH:   if (bus.mem_ready) next_state = DECODE;
               else if (timeout)  next_state = FETCH;
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = rtype_legal ? EXEC : ILLEGAL;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JUMP;
          default:      next_state = ILLEGAL;
        endcase
      end
      MEMADR:  next_state = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   if (bus.mem_ready) next_state = MEMWB;
               else if (timeout)  next_state = FETCH;
      MEMWB:   next_state = FETCH;
      MEMWR:   if (bus.mem_ready || timeout) next_state = FETCH;
      EXEC:    next_state = ALUWB;
      ALUWB:   next_state = FETCH;
      BRANCH:  next_state = FETCH;
      ADDIEX:  next_state = ADDIWB;
      ADDIWB:  next_state = FETCH;
      JUMP:    next_state = FETCH;
      ILLEGAL: next_state = ILLEGAL_HALT ? HALT : FETCH;
      HALT:    next_state = HALT;
      default: next_state = FETCH;
    endcase
  end

  assign bus.state = reset ? FETCH : state_q;

  // During reset present an idle FETCH so nothing is written while the state settles.
  always_comb begin
    bus.mem_req       = 1'b0;
    bus.mem_we        = 1'b0;
    bus.iord          = 1'b0;
    bus.irwrite       = 1'b0;
    bus.pcwrite       = 1'b0;
    bus.pcwritecond   = 1'b0;
    bus.pcsrc         = 2'b00;
    bus.alusrca       = 1'b0;
    bus.alusrcb       = 2'b00;
    bus.alucontrol    = 3'b000;
    bus.regdst        = 1'b0;
    bus.memtoreg      = 1'b0;
    bus.regwrite      = 1'b0;
    bus.illegal_instr = 1'b0;
    bus.bus_error     = 1'b0;
    bus.retired       = 1'b0;
    if (reset) begin
      bus.alusrcb    = 2'b01;
      bus.alucontrol = ALU_ADD;
    end else begin
      case (state_q)
        FETCH: begin
          bus.mem_req    = 1'b1;
          bus.alusrcb    = 2'b01;
          bus.alucontrol = ALU_ADD;
          bus.irwrite    = bus.mem_ready;
          bus.pcwrite    = bus.mem_ready;
          bus.bus_error  = timeout;
        end
        DECODE: begin
          bus.alusrcb    = 2'b11;
          bus.alucontrol = ALU_ADD;
        end
        MEMADR, ADDIEX: begin
          bus.alusrca    = 1'b1;
          bus.alusrcb    = 2'b10;
          bus.alucontrol = ALU_ADD;
        end
        MEMRD: begin
          bus.mem_req   = 1'b1;
          bus.iord      = 1'b1;
          bus.bus_error = timeout;
        end
        MEMWB: begin
          bus.memtoreg = 1'b1;
          bus.regwrite = 1'b1;
          bus.retired  = 1'b1;
        end
        MEMWR: begin
          bus.mem_req   = 1'b1;
          bus.mem_we    = 1'b1;
          bus.iord      = 1'b1;
          bus.retired   = bus.mem_ready;
          bus.bus_error = timeout;
        end
        EXEC: begin
          bus.alusrca = 1'b1;
          case (bus.funct)
            FN_SUB:  bus.alucontrol = ALU_SUB;
            FN_AND:  bus.alucontrol = ALU_AND;
            FN_OR:   bus.alucontrol = ALU_OR;
            FN_SLT:  bus.alucontrol = ALU_SLT;
            default: bus.alucontrol = ALU_ADD;
          endcase
        end
        ALUWB: begin
          bus.regdst   = 1'b1;
          bus.regwrite = 1'b1;
          bus.retired  = 1'b1;
        end
        BRANCH: begin
          bus.alusrca     = 1'b1;
          bus.alucontrol  = ALU_SUB;
          bus.pcsrc       = 2'b01;
          bus.pcwritecond = 1'b1;
          bus.retired     = 1'b1;
        end
        ADDIWB: begin
          bus.regwrite = 1'b1;
          bus.retired  = 1'b1;
        end
        JUMP: begin
          bus.pcsrc   = 2'b10;
          bus.pcwrite = 1'b1;
          bus.retired = 1'b1;
        end
        ILLEGAL: bus.illegal_instr = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
